// File: rtl/neuron_pkg.sv
// Shared types and arithmetic helpers for the streaming neuron MAC.
// Holds the FSM state enum, datapath width helpers and the saturating adder.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    function automatic int lsum_width(input int w, input int lanes);
        return 2 * w + $clog2(lanes) + 1;
    endfunction

    localparam int PROD_WIDTH = prod_width(8);
    localparam int LSUM_WIDTH = lsum_width(8, 8);

    // Clamp a+b into a bw-bit signed range; valid for bw up to 62.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 bw
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/neuron_mac_stream_if.sv
// Beat input, bias/start and result handshake bundle of one neuron.
// The master drives stimulus; the slave is the neuron datapath.
interface neuron_mac_stream_if #(
    parameter int LANES         = 8,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int BIAS_WIDTH    = 32
);
    logic                              START;
    logic signed [BIAS_WIDTH-1:0]      BIAS;
    logic                              IN_VALID;
    logic                              IN_READY;
    logic [LANES*WEIGHTS_WIDTH-1:0]    INPUTS;
    logic [LANES*WEIGHTS_WIDTH-1:0]    WEIGHTS;
    logic                              OUT_VALID;
    logic                              OUT_READY;
    logic signed [BIAS_WIDTH-1:0]      NEURON_OUT;
    logic                              BUSY;

    modport master (
        output START, BIAS, IN_VALID, INPUTS, WEIGHTS, OUT_READY,
        input  IN_READY, OUT_VALID, NEURON_OUT, BUSY
    );

    modport slave (
        input  START, BIAS, IN_VALID, INPUTS, WEIGHTS, OUT_READY,
        output IN_READY, OUT_VALID, NEURON_OUT, BUSY
    );
endinterface

// File: rtl/neuron_mac_stream_lane_reduce.sv
// Combinational masked multiply and lane sum for one beat.
// Lanes past INPUT_SIZE in the final beat contribute zero.
module neuron_lane_reduce
    import neuron_pkg::*;
#(
    parameter int INPUT_SIZE    = 784,
    parameter int LANES         = 8,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int CNT_WIDTH     = 7
) (
    input  logic [LANES*WEIGHTS_WIDTH-1:0]                    inputs,
    input  logic [LANES*WEIGHTS_WIDTH-1:0]                    weights,
    input  logic [CNT_WIDTH-1:0]                              beat,
    output logic signed [lsum_width(WEIGHTS_WIDTH, LANES)-1:0] lane_sum
);
    localparam int W  = WEIGHTS_WIDTH;
    localparam int PW = prod_width(W);
    localparam int LW = lsum_width(W, LANES);

    logic signed [W-1:0]  a;
    logic signed [W-1:0]  b;
    logic signed [PW-1:0] p;

    always_comb begin
        lane_sum = '0;
        a        = '0;
        b        = '0;
        p        = '0;
        for (int l = 0; l < LANES; l++) begin
            a = inputs[l*W +: W];
            b = weights[l*W +: W];
            p = a * b;
            if (int'(beat) * LANES + l < INPUT_SIZE)
                lane_sum = lane_sum + LW'(p);
        end
    end
endmodule

// File: rtl/neuron_mac_stream.sv
// Streaming single-neuron MAC: lane-reduce stage, saturating accumulate, result handshake.
// Define NEURON_RELU_EN to clamp negative results to zero.
module neuron_mac_stream
    import neuron_pkg::*;
#(
    parameter int INPUT_SIZE    = 784,
    parameter int LANES         = 8,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int BIAS_WIDTH    = 32
) (
    input logic                CLK,
    input logic                RESETN,
    neuron_mac_stream_if.slave bus
);
    localparam int NBEATS = (INPUT_SIZE + LANES - 1) / LANES;
    localparam int CW     = $clog2(NBEATS + 1);
    localparam int LW     = lsum_width(WEIGHTS_WIDTH, LANES);
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    state_t                       state;
    logic signed [BIAS_WIDTH-1:0] acc;
    logic signed [BIAS_WIDTH-1:0] nout;
    logic signed [BIAS_WIDTH-1:0] acc_next;
    logic signed [BIAS_WIDTH-1:0] result;
    logic [CW-1:0]                beat_cnt;
    logic signed [LW-1:0]         lsum;
    logic signed [LW-1:0]         s1_sum;
    logic                         s1_vld;
    logic                         accept;

    neuron_lane_reduce #(
        .INPUT_SIZE   (INPUT_SIZE),
        .LANES        (LANES),
        .WEIGHTS_WIDTH(WEIGHTS_WIDTH),
        .CNT_WIDTH    (CW)
    ) u_reduce (
        .inputs  (bus.INPUTS),
        .weights (bus.WEIGHTS),
        .beat    (beat_cnt),
        .lane_sum(lsum)
    );

    assign accept   = bus.IN_VALID && (state == ACCUM);
    assign acc_next = BIAS_WIDTH'(sat_add(64'(acc), 64'(s1_sum), BIAS_WIDTH));

`ifdef NEURON_RELU_EN
    assign result = acc_next[BIAS_WIDTH-1] ? '0 : acc_next;
`else
    assign result = acc_next;
`endif

    assign bus.IN_READY   = (state == ACCUM);
    assign bus.OUT_VALID  = (state == DONE);
    assign bus.BUSY       = (state != IDLE);
    assign bus.NEURON_OUT = nout;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state    <= IDLE;
            acc      <= '0;
            nout     <= '0;
            beat_cnt <= '0;
            s1_sum   <= '0;
            s1_vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        acc      <= bus.BIAS;
                        beat_cnt <= '0;
                        s1_vld   <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (s1_vld) acc <= acc_next;
                    s1_vld <= accept;
                    if (accept) begin
                        s1_sum   <= lsum;
                        beat_cnt <= beat_cnt + CW'(1);
                        if (beat_cnt == LAST) state <= DRAIN;
                    end
                end
                // Last stage-1 sum lands here; the result register is loaded with it.
                DRAIN: begin
                    acc    <= acc_next;
                    nout   <= result;
                    s1_vld <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    if (bus.OUT_READY) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_stream.sv
// Directed bench for neuron_mac_stream: 32-bit and 16-bit bias instances driven in lockstep.
// Results are checked against a per-beat saturating dot-product model and literals.
module tb_neuron_mac_stream;
    localparam int IS = 10;
    localparam int LN = 4;
    localparam int W  = 8;
    localparam int NB = 3;
`ifdef NEURON_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start;
    logic              in_valid;
    logic              out_ready;
    logic signed [31:0] bias;
    logic [LN*W-1:0]   inputs;
    logic [LN*W-1:0]   weights;

    always #5 clk = ~clk;

    neuron_mac_stream_if #(.LANES(LN), .WEIGHTS_WIDTH(W), .BIAS_WIDTH(32)) b32 ();
    neuron_mac_stream_if #(.LANES(LN), .WEIGHTS_WIDTH(W), .BIAS_WIDTH(16)) b16 ();

    assign b32.START     = start;
    assign b32.BIAS      = bias;
    assign b32.IN_VALID  = in_valid;
    assign b32.INPUTS    = inputs;
    assign b32.WEIGHTS   = weights;
    assign b32.OUT_READY = out_ready;
    assign b16.START     = start;
    assign b16.BIAS      = bias[15:0];
    assign b16.IN_VALID  = in_valid;
    assign b16.INPUTS    = inputs;
    assign b16.WEIGHTS   = weights;
    assign b16.OUT_READY = out_ready;

    neuron_mac_stream #(
        .INPUT_SIZE(IS), .LANES(LN), .WEIGHTS_WIDTH(W), .BIAS_WIDTH(32)
    ) u32 (
        .CLK(clk), .RESETN(rst_n), .bus(b32)
    );

    neuron_mac_stream #(
        .INPUT_SIZE(IS), .LANES(LN), .WEIGHTS_WIDTH(W), .BIAS_WIDTH(16)
    ) u16 (
        .CLK(clk), .RESETN(rst_n), .bus(b16)
    );

    int     errs = 0;
    int     checks = 0;
    int     honoured = 0;
    int     pops32 = 0;
    int     pops16 = 0;
    int     in_a [IS];
    int     wt_a [IS];
    int     pad = 100;
    longint q32 [$];
    longint q16 [$];

    function automatic void check(string name, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic longint clamp(longint v, int bw);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (bw - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Dot product with one saturating accumulate per beat.
    function automatic longint model(longint b, int bw);
        longint acc;
        longint s;
        acc = b;
        for (int bt = 0; bt < NB; bt++) begin
            s = 0;
            for (int l = 0; l < LN; l++)
                if (bt * LN + l < IS)
                    s += longint'(in_a[bt*LN+l]) * longint'(wt_a[bt*LN+l]);
            acc = clamp(acc + s, bw);
        end
        if (RELU && acc < 0) acc = 0;
        return acc;
    endfunction

    always @(negedge clk) begin
        if (b32.OUT_VALID === 1'b1) begin
            if (q32.size() == 0) check("spurious_valid32", 1, 0);
            else begin
                check("model32", longint'(b32.NEURON_OUT), q32[0]);
                if (out_ready) begin
                    void'(q32.pop_front());
                    pops32++;
                end
            end
        end
        if (b16.OUT_VALID === 1'b1) begin
            if (q16.size() == 0) check("spurious_valid16", 1, 0);
            else begin
                check("model16", longint'(b16.NEURON_OUT), q16[0]);
                if (out_ready) begin
                    void'(q16.pop_front());
                    pops16++;
                end
            end
        end
    end

    task automatic fill(int a, int w);
        for (int i = 0; i < IS; i++) begin
            in_a[i] = a;
            wt_a[i] = w;
        end
    endtask

    task automatic set_beat(int bt);
        int idx;
        for (int l = 0; l < LN; l++) begin
            idx = bt * LN + l;
            inputs[l*W +: W]  = W'(idx < IS ? in_a[idx] : pad);
            weights[l*W +: W] = W'(idx < IS ? wt_a[idx] : pad);
        end
    endtask

    task automatic flags(string tag, bit rdy, bit vld, bit busy);
        check({tag, "_in_ready32"}, longint'(b32.IN_READY), longint'(rdy));
        check({tag, "_out_valid32"}, longint'(b32.OUT_VALID), longint'(vld));
        check({tag, "_busy32"}, longint'(b32.BUSY), longint'(busy));
        check({tag, "_out_valid16"}, longint'(b16.OUT_VALID), longint'(vld));
        check({tag, "_busy16"}, longint'(b16.BUSY), longint'(busy));
    endtask

    task automatic run(string tag, longint lit32, longint lit16, bit gaps, int hold, bit noise);
        flags({tag, "_idle"}, 0, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = noise;
        honoured++;
        flags({tag, "_accum"}, 1, 0, 1);
        for (int bt = 0; bt < NB; bt++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    check({tag, "_gap_ready"}, longint'(b32.IN_READY), 1);
                end
            end
            set_beat(bt);
            in_valid = 1'b1;
            check({tag, "_beat_ready"}, longint'(b32.IN_READY), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        q32.push_back(model(longint'(bias), 32));
        q16.push_back(model(longint'($signed(bias[15:0])), 16));
        flags({tag, "_drain"}, 0, 0, 1);
        @(posedge clk); #1;
        flags({tag, "_done"}, 0, 1, 1);
        check({tag, "_out32"}, longint'(b32.NEURON_OUT), lit32);
        check({tag, "_out16"}, longint'(b16.NEURON_OUT), lit16);
        repeat (hold) begin
            @(posedge clk); #1;
            flags({tag, "_hold"}, 0, 1, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        flags({tag, "_after"}, 0, 0, 0);
        check({tag, "_kept32"}, longint'(b32.NEURON_OUT), lit32);
        if (noise) begin
            @(posedge clk); #1;
            flags({tag, "_no_restart"}, 0, 0, 0);
        end
    endtask

    initial begin
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        bias = '0;
        inputs = '0;
        weights = '0;
        repeat (2) @(posedge clk);
        #1;
        flags("reset", 0, 0, 0);
        check("reset_out32", longint'(b32.NEURON_OUT), 0);
        check("reset_out16", longint'(b16.NEURON_OUT), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill(1, 2);
        bias = 5;
        run("t1", 25, 25, 0, 0, 0);
        run("t2", 25, 25, 1, 5, 0);

        fill(-128, 127);
        bias = 0;
        run("t3", RELU ? 0 : -162560, RELU ? 0 : -32768, 0, 1, 0);

        fill(1, 3);
        bias = 32767;
        run("t4_pos", 32797, 32767, 0, 0, 0);

        fill(2, -5);
        bias = -32768;
        run("t4_neg", RELU ? 0 : -32868, RELU ? 0 : -32768, 0, 0, 0);

        fill(10, -1);
        for (int i = 0; i < LN; i++) wt_a[i] = 10;
        bias = 32767;
        run("t4_nonsticky", 33107, 32707, 0, 0, 0);

        fill(1, 2);
        bias = 5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        set_beat(0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        flags("t5_reset", 0, 0, 0);
        check("t5_out32", longint'(b32.NEURON_OUT), 0);
        check("t5_out16", longint'(b16.NEURON_OUT), 0);
        run("t5", 25, 25, 0, 0, 0);

        run("t6", 25, 25, 0, 2, 1);

        repeat (3) @(posedge clk);
        #1;
        check("results32", longint'(pops32), longint'(honoured));
        check("results16", longint'(pops16), longint'(honoured));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
